sgd_update_ctrl: RTL and testbench
==================================

// Module: sgd_update_ctrl
// PURPOSE
//  Sequencer for the SGD weight-update datapath. After a CD-k batch, it walks every (i,h) of one
//  I_TILE x H_TILE tile. It issues BRAM reads for acc_pos/acc_neg/w/w_prev_upd, tracks read plus
//  datapath latency, and emits aligned write strobes for W and the momentum store. It also freezes
//  lr/mom/wd for the whole pass. Sits between the AXI-lite control regs and the update datapath.
// PARAMETERS
//  I_TILE  64  visible units per tile
//  H_TILE  64  hidden units per tile
//  RD_LAT  1   BRAM read latency, cycles (>=1)
//  DP_LAT  3   update datapath latency, cycles (>=1)
//  ADDR_W  $clog2(I_TILE*H_TILE)  linear address width (derived)
// PORTS
//  clk         in   1       clock
//  rst         in   1       asynchronous active-low reset
//  start       in   1       begin pass (1-cycle pulse; ignored while busy)
//  abort       in   1       cancel pass, synchronous
//  stall       in   1       backpressure from W writeback/DMA; freezes whole pipe
//  lr_in       in   16      Q0.16 learning rate, sampled on accepted start
//  mom_in      in   16      Q0.16 momentum, sampled on accepted start
//  wd_in       in   16      Q0.16 weight decay, sampled on accepted start
//  lr          out  16      frozen lr to datapath
//  mom         out  16      frozen mom to datapath
//  wd          out  16      frozen wd to datapath
//  rd_en       out  1       read strobe, all four source BRAMs
//  rd_addr     out  ADDR_W  read address = i*H_TILE+h, h innermost
//  pipe_en     out  1       clock-enable for BRAM output regs and datapath (= !stall)
//  wr_addr     out  ADDR_W  write address aligned with w_we
//  w_we        out  1       write W (and w_prev_upd) at wr_addr
//  w_prev_we   out  1       equal to w_we
//  busy        out  1       pass in progress
//  done        out  1       1-cycle pulse at pass completion
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0; FSM=IDLE; counters, pipe valids and lr/mom/wd cleared.
//  FSM states: IDLE, RUN, DRAIN, FIN.
//   IDLE:  start=1 -> latch lr/mom/wd, rd_cnt=0, go RUN; busy=1 from next cycle.
//   RUN:   each cycle with !stall: rd_en=1, rd_addr=rd_cnt, rd_cnt++.
//          After issuing address N-1 (N=I_TILE*H_TILE) -> DRAIN.
//   DRAIN: no reads; wait until the valid shift reg is empty and the last write has been issued.
//          Then -> FIN.
//   FIN:   done=1, busy=0 for one cycle -> IDLE.
//  Latency: valid/address shift register of depth L=RD_LAT+DP_LAT.
//   A read issued at enabled cycle t produces w_we=1, wr_addr=that address at enabled cycle t+L.
//   Stalled cycles do not count toward L.
//  stall=1: rd_en=0, w_we=0, pipe_en=0; counters, shift reg and FSM hold; no strobe lost or duplicated.
//  Exactly N w_we pulses per pass, addresses ascending 0..N-1, none repeated.
//  done fires the cycle after the final w_we (longer if stall is asserted in between).
//  start while busy: ignored, and lr/mom/wd do not re-latch.
//  start in the same cycle as FIN: ignored, because it is only accepted from IDLE.
//  abort (any non-IDLE state): next cycle FSM=IDLE, busy=0, shift-reg valids cleared, rd_en/w_we=0.
//   No done pulse. abort beats stall and start in the same cycle.
//  Reset mid-pass: same as abort but asynchronous; partial tile is left as is, and software re-runs.
//  Counter wrap: rd_cnt never exceeds N-1. ADDR_W holds N-1 exactly for power-of-two tiles.
//  lr/mom/wd outputs are constant from the cycle after start through done.
// CONFIGURATION
//  SGD_CTRL_ACC_CLR_EN defined:
//   Adds outputs acc_clr_we (1) and acc_clr_addr (ADDR_W), both equal to w_we/wr_addr.
//   Each consumed acc_pos/acc_neg word is zeroed through the BRAM second port, so the next batch
//   starts from clean accumulators.
//  Not defined: those ports are absent; software clears the accumulators.
// TESTING
//  I_TILE=H_TILE=4, RD_LAT=1, DP_LAT=3, start, no stall -> rd_en high 16 cycles, addr 0..15.
//   w_we 16 pulses, first 4 cycles after first rd_en; done 1 cycle after last w_we; busy 21 cycles.
//  Same config, stall high for 5 cycles at read 7 -> 16 ordered writes, no gaps/dups;
//   done delayed by exactly 5 cycles.
//  start with lr_in=0x1000, then lr_in=0x2000 and a 2nd start mid-pass -> lr stays 0x1000;
//   2nd start ignored; single done.
//  abort at read 9 -> next cycle busy=0, no further w_we, no done; new start -> full 16-write pass.
//  rst low at cycle 6 of pass -> all outputs 0 immediately; after release, IDLE with lr=0.
//  SGD_CTRL_ACC_CLR_EN -> acc_clr_we/acc_clr_addr match w_we/wr_addr every cycle for a full pass.

Source files
------------

// File: rtl/sgd_update_ctrl.sv
// ---------------------------------------------------------------------------
// sgd_update_ctrl
// Sequencer for the SGD weight-update datapath. One pass walks the
// I_TILE x H_TILE tile in linear order (h innermost). The pass issues one BRAM
// read per address, carries each address through a valid/address shift
// register of depth RD_LAT+DP_LAT, and emits the matching W / momentum
// write strobe. lr/mom/wd are frozen on the accepted start for the whole pass.
//
// Handshake: i_stall freezes the whole pipe. While it is high, o_pipe_en,
// o_rd_en and o_w_we are all low, and no counter, shift stage or FSM state
// advances. A read or write "happens" only in a cycle where its strobe is
// high.
//
// Optional feature macro: SGD_CTRL_ACC_CLR_EN. It adds o_acc_clr_we and
// o_acc_clr_addr, which zero each consumed accumulator word through the
// second BRAM port.
// ---------------------------------------------------------------------------
module sgd_update_ctrl #(
    parameter  int I_TILE = 64,
    parameter  int H_TILE = 64,
    parameter  int RD_LAT = 1,
    parameter  int DP_LAT = 3,
    localparam int N      = I_TILE * H_TILE,
    localparam int ADDR_W = $clog2(N)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_stall,
    input  logic [15:0]       i_lr_in,
    input  logic [15:0]       i_mom_in,
    input  logic [15:0]       i_wd_in,
    output logic [15:0]       o_lr,
    output logic [15:0]       o_mom,
    output logic [15:0]       o_wd,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_pipe_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_w_we,
    output logic              o_w_prev_we,
`ifdef SGD_CTRL_ACC_CLR_EN
    output logic              o_acc_clr_we,
    output logic [ADDR_W-1:0] o_acc_clr_addr,
`endif
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_dbg_state
);

    localparam int                L    = RD_LAT + DP_LAT;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_rd_cnt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_en;
    logic              r_busy;
    logic              r_done;
    logic [15:0]       r_lr;
    logic [15:0]       r_mom;
    logic [15:0]       r_wd;
    logic [L-1:0]      r_vld;
    logic [ADDR_W-1:0] r_wa [L];

    logic w_en;
    logic w_abort;
    logic w_rd_fire;
    logic w_wr_fire;
    logic w_pipe_empty;

    assign w_en         = ~i_stall;
    assign w_abort      = i_abort && (r_state != S_IDLE);
    assign w_rd_fire    = r_rd_en & w_en;
    assign w_wr_fire    = r_vld[L-1] & w_en;
    // The last stage may be writing this cycle. Only the earlier stages must be empty.
    assign w_pipe_empty = (r_vld[L-2:0] == '0);

    // Pass sequencer: address generation, busy/done and parameter freeze
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_rd_cnt  <= '0;
            r_rd_addr <= '0;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_lr      <= '0;
            r_mom     <= '0;
            r_wd      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_lr     <= i_lr_in;
                        r_mom    <= i_mom_in;
                        r_wd     <= i_wd_in;
                        r_rd_cnt <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        r_rd_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_en) begin
                        // Present the next address. The strobe leaves the register in the following cycle.
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_rd_cnt;
                        if (r_rd_cnt == LAST) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_abort) begin
                        r_rd_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_en) begin
                        r_rd_en <= 1'b0;
                        if (!r_rd_en && w_pipe_empty) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    // Done is a single-cycle pulse. A start seen here is dropped.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_rd_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Valid/address delay line that aligns write strobes with datapath output
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < L; k++) begin
                r_wa[k] <= '0;
            end
        end else if (w_abort) begin
            r_vld <= '0;
        end else if (w_en) begin
            r_vld   <= {r_vld[L-2:0], w_rd_fire};
            r_wa[0] <= r_rd_addr;
            for (int k = 1; k < L; k++) begin
                r_wa[k] <= r_wa[k-1];
            end
        end
    end

    assign o_lr        = r_lr;
    assign o_mom       = r_mom;
    assign o_wd        = r_wd;
    assign o_rd_en     = w_rd_fire;
    assign o_rd_addr   = r_rd_addr;
    assign o_pipe_en   = i_rst_n & w_en;
    assign o_wr_addr   = r_wa[L-1];
    assign o_w_we      = w_wr_fire;
    assign o_w_prev_we = w_wr_fire;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_dbg_state = r_state;
`ifdef SGD_CTRL_ACC_CLR_EN
    assign o_acc_clr_we   = w_wr_fire;
    assign o_acc_clr_addr = r_wa[L-1];
`endif

endmodule

// File: tb/tb_sgd_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sgd_update_ctrl
// Directed bench for sgd_update_ctrl with a 4x4 tile, RD_LAT=1 and DP_LAT=3.
// A negedge monitor logs strobes and their cycle numbers. Each scenario then
// compares the log against hand-derived numbers.
// ---------------------------------------------------------------------------
module tb_sgd_update_ctrl;

    localparam int I_T = 4;
    localparam int H_T = 4;
    localparam int N   = I_T * H_T;
    localparam int AW  = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          i_start = 1'b0, i_abort = 1'b0, i_stall = 1'b0;
    logic [15:0]   i_lr_in = '0, i_mom_in = '0, i_wd_in = '0;
    logic [15:0]   o_lr, o_mom, o_wd;
    logic          o_rd_en, o_pipe_en, o_w_we, o_w_prev_we, o_busy, o_done;
    logic [AW-1:0] o_rd_addr, o_wr_addr;
    logic [1:0]    o_dbg_state;
`ifdef SGD_CTRL_ACC_CLR_EN
    logic          o_acc_clr_we;
    logic [AW-1:0] o_acc_clr_addr;
`endif

    sgd_update_ctrl #(.I_TILE(I_T), .H_TILE(H_T), .RD_LAT(1), .DP_LAT(3)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .i_stall     (i_stall),
        .i_lr_in     (i_lr_in),
        .i_mom_in    (i_mom_in),
        .i_wd_in     (i_wd_in),
        .o_lr        (o_lr),
        .o_mom       (o_mom),
        .o_wd        (o_wd),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .o_pipe_en   (o_pipe_en),
        .o_wr_addr   (o_wr_addr),
        .o_w_we      (o_w_we),
        .o_w_prev_we (o_w_prev_we),
`ifdef SGD_CTRL_ACC_CLR_EN
        .o_acc_clr_we   (o_acc_clr_we),
        .o_acc_clr_addr (o_acc_clr_addr),
`endif
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] we_q[$];
    logic [AW-1:0] rd_q[$];
    int first_busy, first_rd, first_we, last_we, done_cyc;
    int busy_cnt, done_cnt, stall_bad, lr_bad, prev_bad, acc_bad;
    logic [15:0] exp_lr = '0, exp_mom = '0, exp_wd = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_log();
        we_q.delete();
        rd_q.delete();
        first_busy = -1; first_rd = -1; first_we = -1; last_we = -1; done_cyc = -1;
        busy_cnt = 0; done_cnt = 0; stall_bad = 0; lr_bad = 0; prev_bad = 0; acc_bad = 0;
    endtask

    // Monitor: sample away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
                if (o_lr !== exp_lr || o_mom !== exp_mom || o_wd !== exp_wd) lr_bad++;
            end
            if (o_rd_en) begin
                rd_q.push_back(o_rd_addr);
                if (first_rd < 0) first_rd = cyc;
            end
            if (o_w_we) begin
                we_q.push_back(o_wr_addr);
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (i_stall && (o_rd_en || o_w_we || o_pipe_en)) stall_bad++;
            if (o_w_prev_we !== o_w_we) prev_bad++;
`ifdef SGD_CTRL_ACC_CLR_EN
            if (o_acc_clr_we !== o_w_we || o_acc_clr_addr !== o_wr_addr) acc_bad++;
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_pass(input logic [15:0] lr, input logic [15:0] mom, input logic [15:0] wd);
        @(posedge clk); #1;
        i_lr_in = lr; i_mom_in = mom; i_wd_in = wd;
        exp_lr  = lr; exp_mom  = mom; exp_wd  = wd;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        if (!seen) check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_read(input string tag, input logic [AW-1:0] addr);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (o_rd_en && o_rd_addr == addr) seen = 1'b1;
        end
        if (!seen) check_eq({tag, "_read_timeout"}, 32'd0, 32'd1);
    endtask

    // Full pass: N reads and N writes, each ascending 0..N-1, with a single done
    task automatic check_pass(input string tag);
        logic [AW-1:0] e;
        check_eq({tag, "_we_cnt"}, we_q.size(), N);
        check_eq({tag, "_rd_cnt"}, rd_q.size(), N);
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back(AW'(i));
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front();
            check_eq({tag, "_wr_addr"}, (i < we_q.size()) ? 32'(we_q[i]) : 32'hFFFF, 32'(e));
            check_eq({tag, "_rd_addr"}, (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hFFFF, 32'(e));
        end
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_stall_leak"}, stall_bad, 0);
        check_eq({tag, "_param_frozen"}, lr_bad, 0);
        check_eq({tag, "_prev_we"}, prev_bad, 0);
`ifdef SGD_CTRL_ACC_CLR_EN
        check_eq({tag, "_acc_clr"}, acc_bad, 0);
`endif
    endtask

    // ---------------- scenarios ----------------
    initial begin
        clear_log();
        #3 rst_n = 1'b0;
        #2;
        check_eq("rst_busy",    o_busy,      0);
        check_eq("rst_done",    o_done,      0);
        check_eq("rst_rd_en",   o_rd_en,     0);
        check_eq("rst_w_we",    o_w_we,      0);
        check_eq("rst_lr",      o_lr,        0);
        check_eq("rst_pipe_en", o_pipe_en,   0);
        check_eq("rst_state",   o_dbg_state, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1) Nominal pass: busy 21 cycles, reads 1 cycle after busy rises, write latency 4
        clear_log();
        start_pass(16'h1234, 16'h8000, 16'h0010);
        wait_done("nom", 100);
        // Start presented during the FIN cycle must be dropped
        i_lr_in = 16'h3333; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        repeat (3) @(negedge clk);
        check_pass("nom");
        check_eq("nom_rd_after_busy", first_rd - first_busy, 1);
        check_eq("nom_we_latency",    first_we - first_rd,   4);
        check_eq("nom_done_after_we", done_cyc - last_we,    1);
        check_eq("nom_busy_cycles",   busy_cnt,              21);
        check_eq("nom_done_cycle",    done_cyc - first_busy, 21);
        check_eq("fin_start_busy",    o_busy,                0);
        check_eq("fin_start_lr",      o_lr,                  16'h1234);

        // 2) Stall for 5 cycles right after read 7: done moves out by exactly 5
        clear_log();
        start_pass(16'h0100, 16'h0200, 16'h0300);
        wait_read("stall", 4'd7);
        @(posedge clk); #1 i_stall = 1'b1;
        repeat (5) @(posedge clk);
        #1 i_stall = 1'b0;
        wait_done("stall", 100);
        repeat (2) @(negedge clk);
        check_pass("stall");
        check_eq("stall_busy_cycles", busy_cnt,              26);
        check_eq("stall_done_cycle",  done_cyc - first_busy, 26);
        check_eq("stall_done_after",  done_cyc - last_we,    1);

        // 3) Second start mid-pass with new lr: ignored, lr stays frozen
        clear_log();
        start_pass(16'h1000, 16'h0001, 16'h0002);
        repeat (5) @(posedge clk);
        #1 i_lr_in = 16'h2000; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        wait_done("restart", 100);
        repeat (4) @(negedge clk);
        check_pass("restart");
        check_eq("restart_lr_hold", o_lr,     16'h1000);
        check_eq("restart_busy",    busy_cnt, 21);

        // 4) Abort right after read 9: no more strobes, no done, then a clean pass
        clear_log();
        start_pass(16'h0ABC, 16'h0DEF, 16'h0123);
        wait_read("abort", 4'd9);
        @(posedge clk); #1 i_abort = 1'b1; i_stall = 1'b1; i_start = 1'b1;
        @(posedge clk); #1 i_abort = 1'b0; i_stall = 1'b0; i_start = 1'b0;
        clear_log();
        @(negedge clk);
        check_eq("abort_busy",  o_busy,      0);
        check_eq("abort_rd_en", o_rd_en,     0);
        check_eq("abort_w_we",  o_w_we,      0);
        check_eq("abort_state", o_dbg_state, 0);
        repeat (20) @(negedge clk);
        check_eq("abort_no_we",   we_q.size(), 0);
        check_eq("abort_no_rd",   rd_q.size(), 0);
        check_eq("abort_no_done", done_cnt,    0);
        clear_log();
        start_pass(16'h0555, 16'h0666, 16'h0777);
        wait_done("post_abort", 100);
        repeat (2) @(negedge clk);
        check_pass("post_abort");

        // 5) Asynchronous reset in cycle 6 of a pass
        clear_log();
        start_pass(16'h4444, 16'h5555, 16'h6666);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mrst_busy",    o_busy,    0);
        check_eq("mrst_rd_en",   o_rd_en,   0);
        check_eq("mrst_rd_addr", o_rd_addr, 0);
        check_eq("mrst_w_we",    o_w_we,    0);
        check_eq("mrst_wr_addr", o_wr_addr, 0);
        check_eq("mrst_lr",      o_lr,      0);
        check_eq("mrst_pipe_en", o_pipe_en, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        clear_log();
        repeat (10) @(negedge clk);
        check_eq("mrst_idle_state", o_dbg_state, 0);
        check_eq("mrst_idle_lr",    o_lr,        0);
        check_eq("mrst_no_we",      we_q.size(), 0);
        check_eq("mrst_no_busy",    busy_cnt,    0);
        clear_log();
        start_pass(16'h7777, 16'h0008, 16'h0009);
        wait_done("post_rst", 100);
        repeat (2) @(negedge clk);
        check_pass("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
